// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller between the CPU
// load/store port and a word-wide data RAM with one cycle of read latency.
module cache_ctrl #(
  parameter int OFFSET_WIDTH = 2,
  parameter int INDEX_WIDTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [31:0] stat_hit,
  output logic [31:0] stat_miss
);

  localparam int LINE_WORDS = 1 << OFFSET_WIDTH;
  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH  = 32 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int K_WIDTH    = OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WB, FILL, ACK} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LINES-1:0]     r_valid;
  logic [LINES-1:0]     r_dirty;
  logic [TAG_WIDTH-1:0] r_tag  [LINES];
  logic [31:0]          r_data [LINES][LINE_WORDS];
  logic [K_WIDTH-1:0]   r_k;
  logic [31:0]          r_dout;
  logic [31:0]          r_hit;
  logic [31:0]          r_miss;

  logic [OFFSET_WIDTH-1:0] w_off;
  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [TAG_WIDTH-1:0]    w_tag;
  logic                    w_hit;
  logic                    w_victim_dirty;
  logic [OFFSET_WIDTH-1:0] w_k_off;
  logic [OFFSET_WIDTH-1:0] w_kprev_off;
  logic                    w_wb_last;
  logic                    w_fill_done;
  logic                    w_lookup;

  assign w_off          = cpu_addr[OFFSET_WIDTH-1:0];
  assign w_idx          = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_tag          = cpu_addr[31 -: TAG_WIDTH];
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
  assign w_k_off        = r_k[OFFSET_WIDTH-1:0];
  assign w_kprev_off    = OFFSET_WIDTH'(r_k - K_WIDTH'(1));
  assign w_wb_last      = (r_k == K_WIDTH'(LINE_WORDS - 1));
  assign w_fill_done    = (r_k == K_WIDTH'(LINE_WORDS));
  assign w_lookup       = (r_state == IDLE) && cpu_req;

  assign cpu_ack   = (r_state == ACK);
  assign cpu_dout  = r_dout;
  assign stat_hit  = r_hit;
  assign stat_miss = r_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Memory-side outputs are decoded from state so reset silences them at once.
  always_comb begin
    w_state_next = r_state;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    case (r_state)
      IDLE: begin
        if (cpu_req) begin
          if (w_hit)               w_state_next = ACK;
          else if (w_victim_dirty) w_state_next = WB;
          else                     w_state_next = FILL;
        end
      end
      WB: begin
        mem_we   = 1'b1;
        mem_addr = {r_tag[w_idx], w_idx, w_k_off};
        mem_din  = r_data[w_idx][w_k_off];
        if (w_wb_last) w_state_next = FILL;
      end
      FILL: begin
        if (w_fill_done) w_state_next = ACK;
        else             mem_addr     = {w_tag, w_idx, w_k_off};
      end
      ACK:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_valid <= '0;
      r_dirty <= '0;
      r_dout  <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
      for (int unsigned i = 0; i < LINES; i++) r_tag[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_k <= '0;
          if (cpu_req) begin
            if (w_hit) begin
              r_hit <= r_hit + 32'd1;
              if (cpu_we) r_dirty[w_idx] <= 1'b1;
              else        r_dout         <= r_data[w_idx][w_off];
            end else begin
              r_miss <= r_miss + 32'd1;
            end
          end
        end
        WB: r_k <= w_wb_last ? '0 : r_k + K_WIDTH'(1);
        FILL: begin
          if (w_fill_done) begin
            r_k            <= '0;
            r_tag[w_idx]   <= w_tag;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= cpu_we;
            // The last word is still on mem_dout this cycle, not yet in the array.
            if (!cpu_we) r_dout <= (w_off == '1) ? mem_dout : r_data[w_idx][w_off];
          end else begin
            r_k <= r_k + K_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A write merged on the final fill cycle is ordered after the capture, so it wins.
  always_ff @(posedge clk) begin
    if (w_lookup && w_hit && cpu_we)
      r_data[w_idx][w_off] <= cpu_din;
    if (r_state == FILL && r_k != '0) begin
      r_data[w_idx][w_kprev_off] <= mem_dout;
      if (w_fill_done && cpu_we)
        r_data[w_idx][w_off] <= cpu_din;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus randomized
// accesses against a line-level cache model and a flat golden memory image.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_din = '0;
  logic [31:0] cpu_dout;
  logic        cpu_ack;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;

  always #5 clk = ~clk;

  cache_ctrl #(.OFFSET_WIDTH(2), .INDEX_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .stat_hit(stat_hit), .stat_miss(stat_miss)
  );

  // data_ram: 64 mapped words, unmapped reads return 0, one-cycle read latency
  logic [31:0] ram [0:63];
  initial for (int i = 0; i < 64; i++) ram[i] <= 32'h1000 + i;
  always @(posedge clk) begin
    if (mem_we && mem_addr < 64) ram[mem_addr[5:0]] <= mem_din;
    mem_dout <= (mem_addr < 64) ? ram[mem_addr[5:0]] : 32'h0;
  end

  int n_cmp = 0;
  int n_err = 0;

  // reference model: per-line valid/tag/dirty plus the CPU-visible memory image
  bit          m_valid [4];
  bit          m_dirty [4];
  logic [31:0] m_tag   [4];
  logic [31:0] golden  [0:511];
  logic [31:0] m_hit, m_miss;

  bit          lg_we   [$];
  logic [31:0] lg_addr [$];
  logic [31:0] lg_din  [$];

  task automatic model_init(input bit from_ram);
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0;
    end
    for (int i = 0; i < 512; i++)
      golden[i] = (i < 64) ? (from_ram ? ram[i] : 32'h1000 + i) : 32'h0;
    m_hit = '0; m_miss = '0;
  endtask

  task automatic predict(input bit we, input logic [31:0] addr, input logic [31:0] din,
                         output int lat, output logic [31:0] val);
    int idx;
    logic [31:0] tag;
    idx = int'((addr / 4) % 4);
    tag = addr / 16;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      lat = 1;
      m_hit = m_hit + 1;
    end else begin
      lat = (m_valid[idx] && m_dirty[idx]) ? 10 : 6;
      m_miss = m_miss + 1;
      m_valid[idx] = 1; m_tag[idx] = tag; m_dirty[idx] = 0;
    end
    if (we) begin
      golden[addr[8:0]] = din;
      m_dirty[idx] = 1;
    end
    val = golden[addr[8:0]];
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] din,
                        input bit b2b, input bit hold, output int lat, output logic [31:0] dout);
    lg_we.delete(); lg_addr.delete(); lg_din.delete();
    if (!b2b) @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    lat = -1; dout = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      lg_we.push_back(mem_we); lg_addr.push_back(mem_addr); lg_din.push_back(mem_din);
      if (cpu_ack) begin
        lat = c; dout = cpu_dout;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout: addr %h got no ack, required ack within 40 cycles", addr);
    end
    if (!hold || lat < 0) cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b required 0", cpu_ack); end
    n_cmp++; if (cpu_dout !== 32'h0) begin n_err++; $display("FAIL rst_dout: got %h required 0", cpu_dout); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
    n_cmp++; if (mem_din !== 32'h0) begin n_err++; $display("FAIL rst_mem_din: got %h required 0", mem_din); end
    n_cmp++; if (stat_hit !== 32'h0) begin n_err++; $display("FAIL rst_hit: got %0d required 0", stat_hit); end
    n_cmp++; if (stat_miss !== 32'h0) begin n_err++; $display("FAIL rst_miss: got %0d required 0", stat_miss); end
    rst = 1'b0;
    model_init(0);
  endtask

  task automatic test_clean_miss();
    int lat, elat;
    logic [31:0] d, ev;
    predict(0, 32'd5, 32'h0, elat, ev);
    access(0, 32'd5, 32'h0, 0, 0, lat, d);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL clean_lat: got %0d required 6", lat); end
    n_cmp++; if (d !== 32'h1005) begin n_err++; $display("FAIL clean_dout: got %h required 00001005", d); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (lg_we[i] !== 1'b0 || lg_addr[i] !== 32'(4 + i)) begin
        n_err++; $display("FAIL clean_fill_addr%0d: got we=%b addr=%h required we=0 addr=%h", i, lg_we[i], lg_addr[i], 4 + i);
      end
    end
    n_cmp++; if (lg_we[4] !== 1'b0) begin n_err++; $display("FAIL clean_fill_last_we: got %b required 0", lg_we[4]); end
    n_cmp++; if (stat_miss !== 32'd1 || stat_hit !== 32'd0) begin n_err++; $display("FAIL clean_stats: got hit=%0d miss=%0d required hit=0 miss=1", stat_hit, stat_miss); end
  endtask

  task automatic test_hit();
    int lat, elat;
    logic [31:0] d, ev;
    predict(0, 32'd6, 32'h0, elat, ev);
    access(0, 32'd6, 32'h0, 0, 0, lat, d);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL hit_lat: got %0d required 1", lat); end
    n_cmp++; if (d !== 32'h1006) begin n_err++; $display("FAIL hit_dout: got %h required 00001006", d); end
    n_cmp++; if (lg_we[0] !== 1'b0 || lg_addr[0] !== 32'h0) begin n_err++; $display("FAIL hit_mem_idle: got we=%b addr=%h required we=0 addr=0", lg_we[0], lg_addr[0]); end
    n_cmp++; if (stat_hit !== 32'd1) begin n_err++; $display("FAIL hit_stat: got %0d required 1", stat_hit); end
  endtask

  task automatic test_dirty_evict();
    int lat, elat;
    logic [31:0] d, ev;
    logic [31:0] exp_wb [4];
    exp_wb[0] = 32'h1004; exp_wb[1] = 32'h1005; exp_wb[2] = 32'hDEADBEEF; exp_wb[3] = 32'h1007;
    predict(1, 32'd6, 32'hDEADBEEF, elat, ev);
    access(1, 32'd6, 32'hDEADBEEF, 0, 0, lat, d);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL wr_hit_lat: got %0d required 1", lat); end
    predict(0, 32'd22, 32'h0, elat, ev);
    access(0, 32'd22, 32'h0, 0, 0, lat, d);
    n_cmp++; if (lat !== 10) begin n_err++; $display("FAIL dirty_lat: got %0d required 10", lat); end
    n_cmp++; if (d !== 32'h1016) begin n_err++; $display("FAIL dirty_dout: got %h required 00001016", d); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (lg_we[i] !== 1'b1 || lg_addr[i] !== 32'(4 + i) || lg_din[i] !== exp_wb[i]) begin
        n_err++; $display("FAIL wb_word%0d: got we=%b addr=%h din=%h required we=1 addr=%h din=%h", i, lg_we[i], lg_addr[i], lg_din[i], 4 + i, exp_wb[i]);
      end
      n_cmp++;
      if (lg_we[4 + i] !== 1'b0 || lg_addr[4 + i] !== 32'(20 + i)) begin
        n_err++; $display("FAIL evict_fill%0d: got we=%b addr=%h required we=0 addr=%h", i, lg_we[4 + i], lg_addr[4 + i], 20 + i);
      end
    end
    n_cmp++; if (ram[6] !== 32'hDEADBEEF) begin n_err++; $display("FAIL ram6_written: got %h required deadbeef", ram[6]); end
  endtask

  task automatic test_write_miss();
    int lat, elat;
    logic [31:0] d, ev;
    predict(1, 32'd40, 32'h55, elat, ev);
    access(1, 32'd40, 32'h55, 0, 0, lat, d);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL wmiss_lat: got %0d required 6", lat); end
    n_cmp++; if (lg_we[0] !== 1'b0 || lg_addr[0] !== 32'd40) begin n_err++; $display("FAIL wmiss_no_wb: got we=%b addr=%h required we=0 addr=28", lg_we[0], lg_addr[0]); end
    predict(0, 32'd40, 32'h0, elat, ev);
    access(0, 32'd40, 32'h0, 0, 0, lat, d);
    n_cmp++; if (lat !== 1 || d !== 32'h55) begin n_err++; $display("FAIL wmiss_readback: got lat=%0d dout=%h required lat=1 dout=00000055", lat, d); end
    n_cmp++; if (stat_hit !== m_hit || stat_miss !== m_miss) begin n_err++; $display("FAIL wmiss_stats: got hit=%0d miss=%0d required hit=%0d miss=%0d", stat_hit, stat_miss, m_hit, m_miss); end
  endtask

  task automatic test_reset_mid_wb();
    int lat, elat;
    logic [31:0] d, ev;
    predict(1, 32'd6, 32'hCAFE0006, elat, ev);
    access(1, 32'd6, 32'hCAFE0006, 0, 0, lat, d);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL rwb_setup_lat: got %0d required 6", lat); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd22;
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'd6) begin n_err++; $display("FAIL rwb_in_wb2: got we=%b addr=%h required we=1 addr=6", mem_we, mem_addr); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rwb_we_drop: got %b required 0", mem_we); end
    n_cmp++; if (stat_hit !== 32'd0 || stat_miss !== 32'd0) begin n_err++; $display("FAIL rwb_stats: got hit=%0d miss=%0d required 0/0", stat_hit, stat_miss); end
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL rwb_no_ack%0d: got %b required 0", i, cpu_ack); end
      @(negedge clk);
    end
    rst = 1'b0;
    n_cmp++; if (ram[6] !== 32'hDEADBEEF || ram[5] !== 32'h1005) begin n_err++; $display("FAIL rwb_ram: got w5=%h w6=%h required w5=00001005 w6=deadbeef", ram[5], ram[6]); end
    model_init(1);
    predict(0, 32'd6, 32'h0, elat, ev);
    access(0, 32'd6, 32'h0, 0, 0, lat, d);
    n_cmp++; if (lat !== 6 || d !== 32'hDEADBEEF) begin n_err++; $display("FAIL rwb_remiss: got lat=%0d dout=%h required lat=6 dout=deadbeef", lat, d); end
    n_cmp++; if (stat_miss !== 32'd1) begin n_err++; $display("FAIL rwb_miss_cnt: got %0d required 1", stat_miss); end
  endtask

  task automatic test_back_to_back();
    int lat, elat;
    logic [31:0] d, ev;
    for (int i = 0; i < 4; i++) begin
      predict(0, 32'(4 + i), 32'h0, elat, ev);
      access(0, 32'(4 + i), 32'h0, (i != 0), (i != 3), lat, d);
      n_cmp++;
      if (lat !== ((i == 0) ? 1 : 2) || d !== ev) begin
        n_err++; $display("FAIL b2b_%0d: got lat=%0d dout=%h required lat=%0d dout=%h", i, lat, d, (i == 0) ? 1 : 2, ev);
      end
    end
    n_cmp++; if (stat_hit !== 32'd4) begin n_err++; $display("FAIL b2b_hits: got %0d required 4", stat_hit); end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [31:0] d, ev, a, wd;
    bit we, hold, prev_hold;
    prev_hold = 0;
    for (int n = 0; n < 60; n++) begin
      we = ($urandom_range(0, 2) == 0);
      a  = 32'($urandom_range(0, 63));
      if (!we && $urandom_range(0, 9) == 0) a = 32'(256 + $urandom_range(0, 63));
      wd = $urandom;
      hold = ($urandom_range(0, 1) == 1);
      predict(we, a, wd, elat, ev);
      access(we, a, wd, prev_hold, hold, lat, d);
      n_cmp++;
      if (lat !== elat + (prev_hold ? 1 : 0)) begin
        n_err++; $display("FAIL rand_lat%0d: addr %h got %0d required %0d", n, a, lat, elat + (prev_hold ? 1 : 0));
      end
      if (!we) begin
        n_cmp++; if (d !== ev) begin n_err++; $display("FAIL rand_dout%0d: addr %h got %h required %h", n, a, d, ev); end
      end
      prev_hold = hold && (lat > 0);
    end
    if (prev_hold) cpu_req = 1'b0;
    n_cmp++; if (stat_hit !== m_hit || stat_miss !== m_miss) begin n_err++; $display("FAIL rand_stats: got hit=%0d miss=%0d required hit=%0d miss=%0d", stat_hit, stat_miss, m_hit, m_miss); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_hit();
    test_dirty_evict();
    test_write_miss();
    test_reset_mid_wb();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller between the CPU load/store port and data_ram.
- Serves CPU word accesses from an internal line store.
- On a miss, writes back a dirty victim line, then refills the line from data_ram over its word-wide, 1-cycle-read-latency port.
- Provides hit/miss statistics counters for the bonus-cache evaluation.

Parameters:
- OFFSET_WIDTH, 2, log2 words per line (LINE_WORDS = 1<<OFFSET_WIDTH).
- INDEX_WIDTH, 2, log2 number of lines.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; held stable with cpu_we/cpu_addr/cpu_din until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  word address.
- cpu_din  in  32  write data.
- cpu_dout  out  32  read data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_we  out  1  data_ram write enable.
- mem_addr  out  32  data_ram word address.
- mem_din  out  32  data_ram write data.
- mem_dout  in  32  data_ram read data; reflects the mem_addr presented on the previous edge.
- stat_hit  out  32  hit counter.
- stat_miss  out  32  miss counter.

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Address split: offset = cpu_addr[OFFSET_WIDTH-1:0]; index = next INDEX_WIDTH bits; tag = cpu_addr[31:OFFSET_WIDTH+INDEX_WIDTH].
- Per-line storage: valid bit, dirty bit, tag, LINE_WORDS x 32-bit data.
- Reset (async, immediate):
  - state=IDLE; all valid/dirty=0.
  - cpu_ack=0, cpu_dout=0.
  - mem_we=0, mem_addr=0, mem_din=0.
  - stat_hit=0, stat_miss=0.
- FSM states: IDLE, WB, FILL, ACK.
- IDLE: mem_we=0, mem_addr=0, mem_din=0. On an edge with cpu_req=1:
  - Hit (valid && tag match):
    - stat_hit+1 → ACK.
    - Read: cpu_dout <= word[offset].
    - Write: word[offset] <= cpu_din, dirty=1.
  - Miss:
    - stat_miss+1.
    - Victim valid&&dirty → WB with k=0; otherwise → FILL with k=0.
- WB: LINE_WORDS cycles, one word per cycle.
  - Drives mem_we=1, mem_addr={victim_tag,index,k}, mem_din=word[k].
  - After k=LINE_WORDS-1 → FILL, k=0.
- FILL: LINE_WORDS+1 cycles.
  - Cycle k (0..LINE_WORDS-1): mem_we=0, mem_addr={req_tag,index,k}.
  - Each cycle k≥1 captures mem_dout into word[k-1].
  - Cycle LINE_WORDS: captures the last word; mem_addr is don't-care, mem_we=0.
  - On exit: tag=req_tag, valid=1, dirty=0; the pending access is performed exactly as for a hit (write merges cpu_din, dirty=1) → ACK.
  - A miss does not also count as a hit.
- ACK: exactly one cycle.
  - cpu_ack=1, cpu_dout valid (holds its last value for writes).
  - cpu_req is not sampled → IDLE.
- Latency from the sampling edge to the cycle in which cpu_ack is high:
  - Hit: 1 cycle.
  - Clean miss: LINE_WORDS+2 cycles.
  - Dirty miss: 2*LINE_WORDS+2 cycles.
- Back-to-back: a held cpu_req is re-sampled in IDLE directly after ACK, giving a minimum 2-cycle issue interval.
- Memory data is cached verbatim, including 0 returned for unmapped addresses. The controller performs no range check.
- Counters wrap modulo 2^32.
- Reset mid-WB/FILL:
  - mem_we drops asynchronously; no ack is issued.
  - Memory words already written stay written.
  - Cache contents are discarded (all invalid).

Test Plan:
(defaults: LINE_WORDS=4, 4 lines; memory preloaded word i = 0x1000+i)
1. After reset, read addr 5 → miss; FILL drives mem_addr 4,5,6,7 with mem_we=0; cpu_ack 6 cycles after sampling, cpu_dout=0x1005; stat_miss=1, stat_hit=0.
2. Then read addr 6 → cpu_ack 1 cycle after sampling, cpu_dout=0x1006, no mem_addr activity, stat_hit=1.
3. Write addr 6 = 0xDEADBEEF (hit), then read addr 22 (index 1, tag 1):
   - WB writes addrs 4..7 = 0x1004, 0x1005, 0xDEADBEEF, 0x1007.
   - FILL reads 20..23.
   - cpu_dout=0x1016, ack 10 cycles after sampling.
   - memory word 6 = 0xDEADBEEF.
4. Write miss addr 40 = 0x55 (index 2, line invalid) → no WB, FILL 40..43, ack; then read 40 → hit, cpu_dout=0x55; stat_miss+1, stat_hit+1.
5. Assert rst during WB cycle 2 of scenario 3 → mem_we=0 immediately, no cpu_ack, counters=0; after release, read addr 6 misses (stat_miss=1).
6. Alternate cpu_req reads of addrs 4,5,6,7 held continuously after one fill → one ack every 2 cycles, cpu_dout 0x1004..0x1007, stat_hit=4.
